johnson_seq_ctrl: RTL

//  Controller that owns an N-stage Johnson counter and sequences it in bounded

---
 rtl/johnson_seq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/johnson_seq_ctrl.sv
// Purpose: runs an N-stage Johnson counter in bounded, stallable, abortable bursts.
// Latency: a burst of S steps raises done S+1 cycles after start is sampled, plus one per hold cycle.
// Backpressure: hold freezes the counter and step budget in RUN; start is only accepted in IDLE.
module johnson_seq_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             dir,
    input  logic             hold,
    input  logic             abort,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     Count_out,
    output logic [2*N-1:0]   phase
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [N-1:0]     cnt_q;
    logic [N-1:0]     cnt_nxt;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_nxt;
    logic             dir_q;
    logic             dir_nxt;

    logic [N-1:0]     cnt_fwd;
    logic [N-1:0]     cnt_rev;
    logic [N-1:0]     cnt_step;

    assign cnt_fwd  = {cnt_q[N-2:0], ~cnt_q[N-1]};
    assign cnt_rev  = {~cnt_q[0], cnt_q[N-1:1]};
    assign cnt_step = dir_q ? cnt_rev : cnt_fwd;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            remaining_q <= remaining_nxt;
            dir_q       <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        remaining_nxt = remaining_q;
        dir_nxt       = dir_q;

        unique case (state_q)
            ST_IDLE: begin
                // clear lands first so a same-cycle start runs from zero
                if (clear) begin
                    cnt_nxt = '0;
                end
                if (start) begin
                    if (steps != '0) begin
                        remaining_nxt = steps;
                        dir_nxt       = dir;
                        state_nxt     = ST_RUN;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    remaining_nxt = '0;
                    state_nxt     = ST_IDLE;
                end else if (!hold) begin
                    cnt_nxt       = cnt_step;
                    remaining_nxt = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase index: low-ones patterns count up from 1, high-ones patterns count down from 2N.
    int ones;
    int ph_idx;

    always_comb begin
        ones = 0;
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(cnt_q[i]);
        end
        if (cnt_q[0]) begin
            ph_idx = ones;
        end else if (ones == 0) begin
            ph_idx = 0;
        end else begin
            ph_idx = 2 * N - ones;
        end
    end

    assign phase     = {{(2*N-1){1'b0}}, 1'b1} << ph_idx;
    assign Count_out = cnt_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);

endmodule
